// File: rtl/ram_stream_reader_if.sv
// ram_stream_reader_if: command, RAM read-port and output-stream signals of
// the RAM stream reader, grouped so the engine and its environment share one
// bundle. The master side is the reader engine itself.
interface ram_stream_reader_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 16
);
    // Command / status
    logic                  start;
    logic [ADDR_WIDTH-1:0] start_addr;
    logic [ADDR_WIDTH:0]   length;
    logic                  busy;
    logic                  done;
    // RAM read port
    logic                  read_enable;
    logic [ADDR_WIDTH-1:0] read_addr;
    logic [DATA_WIDTH-1:0] read_data;
    // Output stream
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;

    modport master (
        input  start, start_addr, length, read_data, out_ready,
        output busy, done, read_enable, read_addr, out_data, out_valid
    );

    modport slave (
        output start, start_addr, length, read_data, out_ready,
        input  busy, done, read_enable, read_addr, out_data, out_valid
    );
endinterface

// File: rtl/ram_stream_reader.sv
// ram_stream_reader: walks a contiguous (wrapping) address range on a
// synchronous-read RAM port and streams the returned words out through a
// 4-entry FIFO with valid/ready handshake. Reads are only issued when the
// FIFO plus the reads still in flight leave room, so returns never overflow.
module ram_stream_reader #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 16
) (
    input logic                  clk,
    input logic                  rst,
    ram_stream_reader_if.master  bus
);
    localparam int LEN_W = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } state_t;

    state_t                state_q, state_d;

    logic [ADDR_WIDTH-1:0] addr_q, addr_d;      // next address to issue
    logic [ADDR_WIDTH-1:0] issue_addr;
    logic [ADDR_WIDTH-1:0] raddr_q;             // registered RAM address
    logic [LEN_W-1:0]      rem_q, rem_d;        // reads still to issue
    logic                  re_q;                // registered RAM read strobe
    logic                  pend_q;              // RAM data valid this cycle
    logic                  issue;
    logic [1:0]            inflight;

    logic [DATA_WIDTH-1:0] mem_q [4];
    logic [1:0]            wptr_q, rptr_q;
    logic [2:0]            cnt_q, cnt_d;
    logic                  push, pop;

    // A read is in flight from the cycle its strobe is registered until its
    // data is captured two edges later.
    assign inflight = {1'b0, re_q} + {1'b0, pend_q};
    assign push     = pend_q;
    assign pop      = (cnt_q != 3'd0) && bus.out_ready;

    // Next-state and issue decision; the first read goes out on the very edge
    // that accepts the start command.
    always_comb begin
        state_d    = state_q;
        issue      = 1'b0;
        issue_addr = addr_q;
        addr_d     = addr_q;
        rem_d      = rem_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.length == '0) begin
                        state_d = FIN;
                    end else begin
                        issue      = 1'b1;
                        issue_addr = bus.start_addr;
                        rem_d      = bus.length - LEN_W'(1);
                        state_d    = (bus.length == LEN_W'(1)) ? DRAIN : RUN;
                    end
                end
            end
            RUN: begin
                // Pops are not credited here, so the check is conservative.
                if ((rem_q != '0) && (({1'b0, cnt_q} + {2'b00, inflight}) < 4'd4)) begin
                    issue = 1'b1;
                    rem_d = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Finish on the edge that pops the last word so done follows it.
                if ((inflight == 2'd0) && (cnt_d == 3'd0)) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (issue) begin
            addr_d = issue_addr + ADDR_WIDTH'(1);
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Issue-side counters and the registered RAM read port; reset discards
    // any read still in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= '0;
            rem_q   <= '0;
            re_q    <= 1'b0;
            raddr_q <= '0;
            pend_q  <= 1'b0;
        end else begin
            addr_q <= addr_d;
            rem_q  <= rem_d;
            re_q   <= issue;
            pend_q <= re_q;
            if (issue) begin
                raddr_q <= issue_addr;
            end
        end
    end

    // FIFO occupancy next value; simultaneous push and pop cancel out.
    always_comb begin
        cnt_d = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + 3'd1;
        end else if (!push && pop) begin
            cnt_d = cnt_q - 3'd1;
        end
    end

    // Output FIFO: returned words always land in an entry, never bypass.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                mem_q[i] <= '0;
            end
            wptr_q <= 2'd0;
            rptr_q <= 2'd0;
            cnt_q  <= 3'd0;
        end else begin
            if (push) begin
                mem_q[wptr_q] <= bus.read_data;
                wptr_q        <= wptr_q + 2'd1;
            end
            if (pop) begin
                rptr_q <= rptr_q + 2'd1;
            end
            cnt_q <= cnt_d;
        end
    end

    assign bus.busy        = (state_q != IDLE);
    assign bus.done        = (state_q == FIN);
    assign bus.read_enable = re_q;
    assign bus.read_addr   = raddr_q;
    assign bus.out_valid   = (cnt_q != 3'd0);
    assign bus.out_data    = mem_q[rptr_q];

endmodule

// File: tb/tb_ram_stream_reader.sv
// tb_ram_stream_reader: drives the stream reader against a 1K x 16
// synchronous-read RAM model; expected addresses and words are queued when a
// transfer is started and consumed as the DUT issues reads and pops words.
module tb_ram_stream_reader;
    logic clk;
    logic rst;

    ram_stream_reader_if #(.ADDR_WIDTH(10), .DATA_WIDTH(16)) bus ();

    ram_stream_reader #(.ADDR_WIDTH(10), .DATA_WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [15:0] ram [1024];
    logic [15:0] ram_rd;

    logic [15:0] exp_data [$];
    logic [9:0]  exp_addr [$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int issued, popped, max_out, n_done;
    int issued_first_pop, first_pop_edge, last_pop_edge;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: data valid the cycle after the sampling edge.
    always @(posedge clk) begin
        if (bus.read_enable) ram_rd <= ram[bus.read_addr];
    end
    assign bus.read_data = ram_rd;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Monitor on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.read_enable) begin
                issued++;
                if (exp_addr.size() == 0) check("rd_addr_extra", 32'(exp_addr.size()), 32'd1);
                else check("rd_addr", 32'(bus.read_addr), 32'(exp_addr.pop_front()));
            end
            if (issued - popped > max_out) max_out = issued - popped;
            if (bus.out_valid && bus.out_ready) begin
                if (popped == 0) begin
                    issued_first_pop = issued;
                    first_pop_edge   = cyc + 1;
                end
                popped++;
                last_pop_edge = cyc + 1;
                if (exp_data.size() == 0) check("stream_extra", 32'(exp_data.size()), 32'd1);
                else check("stream_data", 32'(bus.out_data), 32'(exp_data.pop_front()));
            end
            if (bus.done) n_done++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_busy"},      32'(bus.busy),        32'd0);
        check({pfx, "_done"},      32'(bus.done),        32'd0);
        check({pfx, "_rd_en"},     32'(bus.read_enable), 32'd0);
        check({pfx, "_rd_addr"},   32'(bus.read_addr),   32'd0);
        check({pfx, "_out_valid"}, 32'(bus.out_valid),   32'd0);
        check({pfx, "_out_data"},  32'(bus.out_data),    32'd0);
    endtask

    // Queue expectations, then present start for one edge (E0).
    task automatic start_xfer(input logic [9:0] a, input logic [10:0] len);
        exp_data.delete();
        exp_addr.delete();
        issued = 0; popped = 0; max_out = 0; n_done = 0;
        issued_first_pop = 0; first_pop_edge = 0; last_pop_edge = 0;
        for (int k = 0; k < int'(len); k++) begin
            logic [9:0] ad;
            ad = a + 10'(k);
            exp_addr.push_back(ad);
            exp_data.push_back(ram[ad]);
        end
        bus.start      = 1'b1;
        bus.start_addr = a;
        bus.length     = len;
        tick();
        bus.start      = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc, input bit rnd, input logic [10:0] len);
        int n;
        n = 0;
        while (!bus.done && n < max_cyc) begin
            if (rnd) bus.out_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        check("done_seen", 32'(bus.done), 32'd1);
        if (bus.done) begin
            check("busy_at_done", 32'(bus.busy), 32'd1);
            if (len != 0) check("done_timing", 32'(cyc), 32'(last_pop_edge));
            bus.out_ready = 1'b1;
            tick();
            check("done_pulse", 32'(bus.done), 32'd0);
            check("busy_after", 32'(bus.busy), 32'd0);
            check("read_count", 32'(issued), 32'(len));
            check("words_left", 32'(exp_data.size()), 32'd0);
            check("done_count", 32'(n_done), 32'd1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int snap, n;
        for (int k = 0; k < 1024; k++) ram[k] = 16'h100 + 16'(k);
        ram_rd         = '0;
        rst            = 1'b1;
        bus.start      = 1'b0;
        bus.start_addr = '0;
        bus.length     = '0;
        bus.out_ready  = 1'b0;
        issued = 0; popped = 0; max_out = 0; n_done = 0;
        repeat (2) tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();

        // Basic read with latency and throughput
        bus.out_ready = 1'b1;
        start_xfer(10'd0, 11'd8);
        check("lat_busy", 32'(bus.busy), 32'd1);
        check("lat_rd_en", 32'(bus.read_enable), 32'd1);
        check("lat_valid_e0", 32'(bus.out_valid), 32'd0);
        tick();
        check("lat_valid_e1", 32'(bus.out_valid), 32'd0);
        tick();
        check("lat_valid_e2", 32'(bus.out_valid), 32'd1);
        check("first_word", 32'(bus.out_data), 32'h100);
        wait_done(100, 1'b0, 11'd8);
        check("throughput", 32'(last_pop_edge - first_pop_edge), 32'd7);

        // Wrap-around
        start_xfer(10'd1022, 11'd4);
        wait_done(100, 1'b0, 11'd4);

        // Back-pressure
        start_xfer(10'h10, 11'd10);
        for (int i = 0; i < 8; i++) begin
            bus.out_ready = ~bus.out_ready;
            tick();
        end
        bus.out_ready = 1'b0;
        repeat (10) tick();
        snap = issued;
        repeat (10) tick();
        check("stall_no_read", 32'(issued), 32'(snap));
        check("stall_outstanding", 32'(issued - popped), 32'd4);
        check("max_outstanding_gt4", 32'(max_out > 4), 32'd0);
        check("first_pop_gt4", 32'(issued_first_pop > 4), 32'd0);
        bus.out_ready = 1'b1;
        wait_done(200, 1'b0, 11'd10);

        // Zero length
        start_xfer(10'd5, 11'd0);
        check("zero_busy", 32'(bus.busy), 32'd1);
        check("zero_done", 32'(bus.done), 32'd1);
        check("zero_rd_en", 32'(bus.read_enable), 32'd0);
        wait_done(10, 1'b0, 11'd0);

        // Start while busy is ignored
        start_xfer(10'd300, 11'd16);
        repeat (3) tick();
        bus.start      = 1'b1;
        bus.start_addr = 10'd700;
        bus.length     = 11'd5;
        tick();
        bus.start      = 1'b0;
        wait_done(200, 1'b0, 11'd16);

        // Reset mid-transfer
        start_xfer(10'd200, 11'd20);
        n = 0;
        while (popped < 5 && n < 100) begin
            tick();
            n++;
        end
        check("rst_popped5", 32'(popped >= 5), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_outputs("midrst");
        exp_data.delete();
        exp_addr.delete();
        n_done = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post_rst_valid", 32'(bus.out_valid), 32'd0);
        end
        check("post_rst_no_done", 32'(n_done), 32'd0);
        start_xfer(10'd100, 11'd2);
        wait_done(50, 1'b0, 11'd2);

        // Full sweep with random ready
        start_xfer(10'd512, 11'd1024);
        wait_done(8000, 1'b1, 11'd1024);
        check("sweep_addrs_left", 32'(exp_addr.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
